// File: rtl/lsu_mem_ctrl_if.sv
// Data-memory port of the load/store unit: a request/ready channel carrying
// word address, byte enables and write data, plus a read-data return channel.
// master = LSU side, slave = memory side.
interface lsu_mem_ctrl_if;
   logic        mem_req;
   logic        mem_we;
   logic [29:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  mem_ready, mem_rvalid, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output mem_ready, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// RV32I load/store unit. Takes the ALU result as byte address, issues one
// access on the memory port, stalls the core while it is outstanding, and
// returns aligned, sign/zero-extended load data with a one-cycle done pulse.
// Optional feature: define LSU_TIMEOUT_EN to abort an access that spends
// TIMEOUT_CYCLES cycles in REQ/WAIT_R (done with o_lsu_err=1, data 0).
module lsu_mem_ctrl #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_lsu_valid,
   input  logic                 i_lsu_we,
   input  logic [2:0]           i_funct3,
   input  logic [31:0]          i_lsu_addr,
   input  logic [31:0]          i_st_data,
   output logic                 o_lsu_stall,
   output logic                 o_lsu_done,
   output logic [31:0]          o_ld_data,
   output logic                 o_lsu_misalign,
   output logic                 o_lsu_err,
   lsu_mem_ctrl_if.master       mem
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      WAIT_R = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t      state_q;
   logic [29:0] addr_q;
   logic [1:0]  off_q;
   logic [2:0]  f3_q;
   logic        we_q;
   logic [3:0]  be_q;
   logic [31:0] wdata_q;
   logic        req_q;
   logic        done_q;
   logic [31:0] ld_data_q;

   logic        misalign_req;
   logic        start;
   logic        timeout;

   // Byte enables for a store; size comes from funct3[1:0], 1x is a word.
   function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
      logic [3:0] be;
      case (size)
         2'b00:   be = 4'b0001 << off;
         2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   // Replicate the store operand across all lanes so any enabled lane is correct.
   function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] d);
      logic [31:0] w;
      case (size)
         2'b00:   w = {4{d[7:0]}};
         2'b01:   w = {2{d[15:0]}};
         default: w = d;
      endcase
      return w;
   endfunction

   // Pick the addressed lane of the read word and extend it; funct3[2] selects zero-extension.
   function automatic logic [31:0] load_extend(input logic [31:0] rdata, input logic [1:0] off,
                                               input logic [2:0] f3);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic [31:0]        r;
      b = rdata[{off, 3'b000} +: 8];
      h = rdata[{off[1], 4'b0000} +: 16];
      case (f3[1:0])
         2'b00:   r = f3[2] ? {24'b0, b} : 32'(b);
         2'b01:   r = f3[2] ? {16'b0, h} : 32'(h);
         default: r = rdata;
      endcase
      return r;
   endfunction

   // Misalignment of the request presented on the core side.
   always_comb begin
      misalign_req = 1'b0;
      case (i_funct3[1:0])
         2'b00:   misalign_req = 1'b0;
         2'b01:   misalign_req = i_lsu_addr[0];
         default: misalign_req = |i_lsu_addr[1:0];
      endcase
   end

   // Gated by i_reset so every output reads 0 while reset is held.
   assign start          = i_reset & (state_q == IDLE) & i_lsu_valid & ~misalign_req;
   assign o_lsu_misalign = i_reset & (state_q == IDLE) & i_lsu_valid & misalign_req;
   assign o_lsu_stall    = start | (state_q == REQ) | (state_q == WAIT_R);
   assign o_lsu_done     = done_q;
   assign o_ld_data      = ld_data_q;

   assign mem.mem_req    = req_q;
   assign mem.mem_we     = we_q;
   assign mem.mem_addr   = addr_q;
   assign mem.mem_be     = be_q;
   assign mem.mem_wdata  = wdata_q;

`ifdef LSU_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CNT_W-1:0] cnt_q;
   logic             err_q;

   assign timeout   = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
   assign o_lsu_err = err_q;

   // Cycles spent in REQ/WAIT_R; restarts with every accepted request.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         cnt_q <= '0;
      end else if (start) begin
         cnt_q <= '0;
      end else if ((state_q == REQ) || (state_q == WAIT_R)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end
`else
   assign timeout   = 1'b0;
   assign o_lsu_err = 1'b0;
`endif

   // Access sequencer: latch the request, run the memory handshake, report completion.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         off_q     <= '0;
         f3_q      <= '0;
         we_q      <= 1'b0;
         be_q      <= '0;
         wdata_q   <= '0;
         req_q     <= 1'b0;
         done_q    <= 1'b0;
         ld_data_q <= '0;
`ifdef LSU_TIMEOUT_EN
         err_q     <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  addr_q  <= i_lsu_addr[31:2];
                  off_q   <= i_lsu_addr[1:0];
                  f3_q    <= i_funct3;
                  we_q    <= i_lsu_we;
                  be_q    <= i_lsu_we ? store_be(i_funct3[1:0], i_lsu_addr[1:0]) : 4'b1111;
                  wdata_q <= i_lsu_we ? store_wdata(i_funct3[1:0], i_st_data) : 32'h0;
                  req_q   <= 1'b1;
                  state_q <= REQ;
               end
            end
            REQ: begin
               if (mem.mem_ready) begin
                  req_q <= 1'b0;
                  if (we_q) begin
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end else if (mem.mem_rvalid) begin
                     ld_data_q <= load_extend(mem.mem_rdata, off_q, f3_q);
                     done_q    <= 1'b1;
                     state_q   <= DONE;
                  end else begin
                     state_q <= WAIT_R;
                  end
               end else if (timeout) begin
                  req_q     <= 1'b0;
                  ld_data_q <= '0;
                  done_q    <= 1'b1;
                  state_q   <= DONE;
`ifdef LSU_TIMEOUT_EN
                  err_q     <= 1'b1;
`endif
               end
            end
            WAIT_R: begin
               if (mem.mem_rvalid) begin
                  ld_data_q <= load_extend(mem.mem_rdata, off_q, f3_q);
                  done_q    <= 1'b1;
                  state_q   <= DONE;
               end else if (timeout) begin
                  ld_data_q <= '0;
                  done_q    <= 1'b1;
                  state_q   <= DONE;
`ifdef LSU_TIMEOUT_EN
                  err_q     <= 1'b1;
`endif
               end
            end
            default: begin
               // DONE: core advances on this edge, so i_lsu_valid is not looked at.
               done_q    <= 1'b0;
               ld_data_q <= '0;
               state_q   <= IDLE;
`ifdef LSU_TIMEOUT_EN
               err_q     <= 1'b0;
`endif
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Testbench for lsu_mem_ctrl: vector table of loads/stores driven through a
// small memory responder, scoreboard of expected port/result values, plus
// hand-written reset-abort, idle-rvalid and (with LSU_TIMEOUT_EN) timeout sequences.
module tb_lsu_mem_ctrl;

   localparam int TO_CYC = 64;

   logic        i_clk;
   logic        i_reset;
   logic        i_lsu_valid;
   logic        i_lsu_we;
   logic [2:0]  i_funct3;
   logic [31:0] i_lsu_addr;
   logic [31:0] i_st_data;
   logic        o_lsu_stall;
   logic        o_lsu_done;
   logic [31:0] o_ld_data;
   logic        o_lsu_misalign;
   logic        o_lsu_err;

   lsu_mem_ctrl_if mem_if ();

   lsu_mem_ctrl #(.TIMEOUT_CYCLES(TO_CYC)) dut (
      .i_clk          (i_clk),
      .i_reset        (i_reset),
      .i_lsu_valid    (i_lsu_valid),
      .i_lsu_we       (i_lsu_we),
      .i_funct3       (i_funct3),
      .i_lsu_addr     (i_lsu_addr),
      .i_st_data      (i_st_data),
      .o_lsu_stall    (o_lsu_stall),
      .o_lsu_done     (o_lsu_done),
      .o_ld_data      (o_ld_data),
      .o_lsu_misalign (o_lsu_misalign),
      .o_lsu_err      (o_lsu_err),
      .mem            (mem_if.master)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] sdata;
      logic [31:0] rdata;
      int          rdy_dly;
      int          rv_dly;
      logic        exp_mis;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata;
      logic [31:0] exp_ld;
   } vec_t;

   typedef struct {
      logic [29:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic        we;
      logic [31:0] ld;
      int          lat;
   } exp_t;

   localparam int NV = 14;
   vec_t vecs [NV];
   exp_t sbq [$];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      exp_t e;
      exp_t p;
      int   cyc;
      int   req_cnt;
      int   wait_cnt;
      bit   accepted;
      bit   fin;
      bit   seen_req;
      @(negedge i_clk);
      i_lsu_valid = 1'b1;
      i_lsu_we    = v.we;
      i_funct3    = v.f3;
      i_lsu_addr  = v.addr;
      i_st_data   = v.sdata;
      mem_if.mem_ready  = 1'b0;
      mem_if.mem_rvalid = 1'b0;
      #1;
      chk($sformatf("v%0d misalign", idx), 32'(o_lsu_misalign), 32'(v.exp_mis));
      if (v.exp_mis) begin
         chk($sformatf("v%0d mis_stall", idx), 32'(o_lsu_stall), 32'h0);
         @(posedge i_clk);
         #1;
         chk($sformatf("v%0d mis_req", idx), 32'(mem_if.mem_req), 32'h0);
         chk($sformatf("v%0d mis_stall2", idx), 32'(o_lsu_stall), 32'h0);
         i_lsu_valid = 1'b0;
         return;
      end
      chk($sformatf("v%0d stall0", idx), 32'(o_lsu_stall), 32'h1);
      e.addr  = v.addr[31:2];
      e.be    = v.exp_be;
      e.wdata = v.exp_wdata;
      e.we    = v.we;
      e.ld    = v.exp_ld;
      e.lat   = 2 + v.rdy_dly + v.rv_dly;
      sbq.push_back(e);
      cyc = 0; req_cnt = 0; wait_cnt = 0;
      accepted = 1'b0; fin = 1'b0; seen_req = 1'b0;
      while (!fin && cyc < 200) begin
         @(posedge i_clk);
         @(negedge i_clk);
         cyc++;
         mem_if.mem_ready  = 1'b0;
         mem_if.mem_rvalid = 1'b0;
         mem_if.mem_rdata  = 32'h5555AAAA;
         if (o_lsu_done) begin
            p = sbq.pop_front();
            if (!p.we) chk($sformatf("v%0d ld_data", idx), o_ld_data, p.ld);
            chk($sformatf("v%0d err", idx), 32'(o_lsu_err), 32'h0);
            chk($sformatf("v%0d latency", idx), 32'(cyc), 32'(p.lat));
            chk($sformatf("v%0d done_stall", idx), 32'(o_lsu_stall), 32'h0);
            i_lsu_valid = 1'b0;
            fin = 1'b1;
         end else if (mem_if.mem_req) begin
            if (!seen_req) begin
               seen_req = 1'b1;
               chk($sformatf("v%0d addr", idx), 32'(mem_if.mem_addr), 32'(sbq[0].addr));
               chk($sformatf("v%0d be", idx), 32'(mem_if.mem_be), 32'(sbq[0].be));
               chk($sformatf("v%0d we", idx), 32'(mem_if.mem_we), 32'(sbq[0].we));
               if (sbq[0].we) chk($sformatf("v%0d wdata", idx), mem_if.mem_wdata, sbq[0].wdata);
            end
            if (req_cnt == v.rdy_dly) begin
               mem_if.mem_ready = 1'b1;
               accepted = 1'b1;
               if (!v.we && v.rv_dly == 0) begin
                  mem_if.mem_rvalid = 1'b1;
                  mem_if.mem_rdata  = v.rdata;
               end
            end
            req_cnt++;
         end else if (accepted && !v.we) begin
            chk($sformatf("v%0d wait_stall", idx), 32'(o_lsu_stall), 32'h1);
            wait_cnt++;
            if (wait_cnt == v.rv_dly) begin
               mem_if.mem_rvalid = 1'b1;
               mem_if.mem_rdata  = v.rdata;
            end
         end
      end
      if (!fin) begin
         errors++;
         checks++;
         $display("FAIL v%0d completion: got no done within 200 cycles, required done", idx);
         i_lsu_valid = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   initial begin
      //          we    f3      addr          sdata         rdata         rdy rv  mis   be       wdata         ld
      vecs[0]  = '{1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        0,  0,  1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h0};
      vecs[1]  = '{1'b0, 3'b000, 32'h0000_0103, 32'h0,         32'h80FF_0000, 0, 3,  1'b0, 4'b1111, 32'h0,         32'hFFFF_FF80};
      vecs[2]  = '{1'b0, 3'b101, 32'h0000_0102, 32'h0,         32'hBEEF_1234, 0, 0,  1'b0, 4'b1111, 32'h0,         32'h0000_BEEF};
      vecs[3]  = '{1'b1, 3'b001, 32'h0000_0102, 32'h0000_ABCD, 32'h0,        2,  0,  1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0};
      vecs[4]  = '{1'b0, 3'b010, 32'h0000_0101, 32'h0,         32'h0,        0,  0,  1'b1, 4'b0000, 32'h0,         32'h0};
      vecs[5]  = '{1'b1, 3'b000, 32'h0000_0101, 32'h1234_565A, 32'h0,        1,  0,  1'b0, 4'b0010, 32'h5A5A_5A5A, 32'h0};
      vecs[6]  = '{1'b0, 3'b001, 32'h0000_0100, 32'h0,         32'h1234_8001, 1, 1,  1'b0, 4'b1111, 32'h0,         32'hFFFF_8001};
      vecs[7]  = '{1'b0, 3'b100, 32'h0000_0101, 32'h0,         32'h0000_9A00, 0, 0,  1'b0, 4'b1111, 32'h0,         32'h0000_009A};
      vecs[8]  = '{1'b0, 3'b010, 32'h0000_0104, 32'h0,         32'hCAFE_F00D, 3, 2,  1'b0, 4'b1111, 32'h0,         32'hCAFE_F00D};
      vecs[9]  = '{1'b1, 3'b001, 32'h0000_0101, 32'h0000_1111, 32'h0,        0,  0,  1'b1, 4'b0000, 32'h0,         32'h0};
      vecs[10] = '{1'b0, 3'b101, 32'h0000_0103, 32'h0,         32'h0,        0,  0,  1'b1, 4'b0000, 32'h0,         32'h0};
      vecs[11] = '{1'b0, 3'b000, 32'h0000_0102, 32'h0,         32'h007F_0000, 0, 1,  1'b0, 4'b1111, 32'h0,         32'h0000_007F};
      vecs[12] = '{1'b0, 3'b011, 32'h0000_0108, 32'h0,         32'h1122_3344, 0, 0,  1'b0, 4'b1111, 32'h0,         32'h1122_3344};
      vecs[13] = '{1'b0, 3'b001, 32'h0000_0102, 32'h0,         32'h8000_0000, 2, 0,  1'b0, 4'b1111, 32'h0,         32'hFFFF_8000};

      // Reset state, with a valid aligned request presented during reset.
      i_reset     = 1'b0;
      i_lsu_valid = 1'b1;
      i_lsu_we    = 1'b0;
      i_funct3    = 3'b010;
      i_lsu_addr  = 32'h0000_0100;
      i_st_data   = 32'h0;
      mem_if.mem_ready  = 1'b0;
      mem_if.mem_rvalid = 1'b0;
      mem_if.mem_rdata  = 32'h0;
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      chk("rst stall", 32'(o_lsu_stall), 32'h0);
      chk("rst done", 32'(o_lsu_done), 32'h0);
      chk("rst ld_data", o_ld_data, 32'h0);
      chk("rst misalign", 32'(o_lsu_misalign), 32'h0);
      chk("rst err", 32'(o_lsu_err), 32'h0);
      chk("rst req", 32'(mem_if.mem_req), 32'h0);
      chk("rst addr", 32'(mem_if.mem_addr), 32'h0);
      chk("rst be", 32'(mem_if.mem_be), 32'h0);
      i_lsu_valid = 1'b0;
      i_reset     = 1'b1;

      // rvalid while idle must not produce a completion.
      @(negedge i_clk);
      mem_if.mem_rvalid = 1'b1;
      mem_if.mem_rdata  = 32'hFFFF_FFFF;
      @(posedge i_clk);
      #1;
      chk("idle_rvalid done", 32'(o_lsu_done), 32'h0);
      chk("idle_rvalid stall", 32'(o_lsu_stall), 32'h0);
      mem_if.mem_rvalid = 1'b0;

      for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

      // Reset while in REQ: request drops immediately.
      @(negedge i_clk);
      i_lsu_valid = 1'b1; i_lsu_we = 1'b0; i_funct3 = 3'b010; i_lsu_addr = 32'h0000_0200;
      @(negedge i_clk);
      chk("rstreq req_before", 32'(mem_if.mem_req), 32'h1);
      #2 i_reset = 1'b0;
      #1;
      chk("rstreq req_after", 32'(mem_if.mem_req), 32'h0);
      chk("rstreq stall_after", 32'(o_lsu_stall), 32'h0);
      @(negedge i_clk);
      i_lsu_valid = 1'b0;
      i_reset     = 1'b1;

      // Reset while in WAIT_R: stall drops at once, late rvalid is ignored.
      @(negedge i_clk);
      i_lsu_valid = 1'b1; i_lsu_we = 1'b0; i_funct3 = 3'b010; i_lsu_addr = 32'h0000_0204;
      @(negedge i_clk);
      mem_if.mem_ready = 1'b1;
      @(negedge i_clk);
      mem_if.mem_ready = 1'b0;
      chk("rstwait req", 32'(mem_if.mem_req), 32'h0);
      chk("rstwait stall_before", 32'(o_lsu_stall), 32'h1);
      #2 i_reset = 1'b0;
      #1;
      chk("rstwait stall_after", 32'(o_lsu_stall), 32'h0);
      chk("rstwait req_after", 32'(mem_if.mem_req), 32'h0);
      @(negedge i_clk);
      i_lsu_valid = 1'b0;
      i_reset     = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge i_clk);
         mem_if.mem_rvalid = 1'b1;
         mem_if.mem_rdata  = 32'h1234_5678;
         #1;
         chk($sformatf("rstwait no_done%0d", k), 32'(o_lsu_done), 32'h0);
         chk($sformatf("rstwait no_stall%0d", k), 32'(o_lsu_stall), 32'h0);
      end
      @(negedge i_clk);
      mem_if.mem_rvalid = 1'b0;
      #1;
      chk("rstwait no_done_end", 32'(o_lsu_done), 32'h0);

`ifdef LSU_TIMEOUT_EN
      // Timeout: memory never accepts; expect done+err after TO_CYC cycles in REQ.
      begin
         int  cyc;
         bit  fin;
         @(negedge i_clk);
         i_lsu_valid = 1'b1; i_lsu_we = 1'b0; i_funct3 = 3'b010; i_lsu_addr = 32'h0000_0300;
         cyc = 0; fin = 1'b0;
         while (!fin && cyc < TO_CYC + 20) begin
            @(posedge i_clk);
            @(negedge i_clk);
            cyc++;
            if (o_lsu_done) begin
               chk("timeout err", 32'(o_lsu_err), 32'h1);
               chk("timeout ld_data", o_ld_data, 32'h0);
               chk("timeout latency", 32'(cyc), 32'(TO_CYC + 1));
               i_lsu_valid = 1'b0;
               fin = 1'b1;
            end
         end
         if (!fin) begin
            errors++;
            checks++;
            $display("FAIL timeout completion: got no done, required done+err");
            i_lsu_valid = 1'b0;
         end
      end
`endif

      // Normal access after the abort sequences.
      run_vec(vecs[0], 100);
      run_vec(vecs[1], 101);

      chk("scoreboard empty", 32'(sbq.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
